uart_rx_word: RTL and testbench



---
 rtl/uart_rx_word.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_word.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word.sv
// Serial RX that assembles BYTES_PER_WORD characters into a little-endian word,
// with parity/stop checking, glitch rejection, inter-byte timeout and overrun.
// Latency: word valid 1 clk after final stop sample; backpressure via i_ready, overflow drops new word.
module uart_rx_word #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 115_200,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int BYTES_PER_WORD = 2,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_rx,
  input  logic                                i_ready,
  output logic [DATA_BITS*BYTES_PER_WORD-1:0] o_data,
  output logic                                o_valid,
  output logic                                o_frame_err,
  output logic                                o_parity_err,
  output logic                                o_timeout,
  output logic                                o_overrun
);

  localparam int BAUD_TICK = CLK_FREQ / BAUD;
  localparam int HALF_TICK = BAUD_TICK / 2;
  localparam int WW        = DATA_BITS * BYTES_PER_WORD;
  localparam int TO_LIMIT  = BAUD_TICK * TIMEOUT_BITS;
  localparam int CW        = $clog2(BAUD_TICK + 1);
  localparam int TW        = $clog2(TO_LIMIT + 1);
  localparam int IW        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_s;
  logic                   rx_prev;
  logic [CW-1:0]          cnt;
  logic [TW-1:0]          tcnt;
  logic [2:0]             bit_idx;
  logic [IW-1:0]          byte_idx;
  logic [DATA_BITS-1:0]   char_q;
  logic                   par_bad;
  logic                   par_exp;
  logic [WW-1:0]          word_buf;
  logic [WW-1:0]          word_next;

  // Even parity bit equals the XOR of the data; odd parity is its inverse.
  assign par_exp = (PARITY == 1) ? ~(^char_q) : (^char_q);

  // Partial lanes live in word_buf; o_data only sees them on a full word load.
  always_comb begin
    word_next = word_buf;
    word_next[int'(byte_idx)*DATA_BITS +: DATA_BITS] = char_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      rx_prev      <= 1'b1;
      state        <= S_IDLE;
      cnt          <= '0;
      tcnt         <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      char_q       <= '0;
      par_bad      <= 1'b0;
      word_buf     <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_timeout    <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      rx_meta      <= i_rx;
      rx_s         <= rx_meta;
      rx_prev      <= rx_s;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_timeout    <= 1'b0;
      o_overrun    <= 1'b0;
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= S_START;
            cnt   <= CW'(HALF_TICK - 1);
            tcnt  <= '0;
          end else if (byte_idx != '0) begin
            if (tcnt == TW'(TO_LIMIT - 1)) begin
              o_timeout <= 1'b1;
              byte_idx  <= '0;
              tcnt      <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end

        S_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            state <= S_IDLE;
          end else begin
            state   <= S_DATA;
            cnt     <= CW'(BAUD_TICK - 1);
            bit_idx <= '0;
            par_bad <= 1'b0;
          end
        end

        S_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            char_q[bit_idx] <= rx_s;
            cnt             <= CW'(BAUD_TICK - 1);
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            par_bad <= (rx_s != par_exp);
            cnt     <= CW'(BAUD_TICK - 1);
            state   <= S_STOP;
          end
        end

        S_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= S_IDLE;
            tcnt  <= '0;
            if (!rx_s) begin
              o_frame_err <= 1'b1;
              byte_idx    <= '0;
            end else if (par_bad) begin
              o_parity_err <= 1'b1;
              byte_idx     <= '0;
            end else if (byte_idx == IW'(BYTES_PER_WORD - 1)) begin
              byte_idx <= '0;
              if (!o_valid || i_ready) begin
                o_data  <= word_next;
                o_valid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end else begin
              word_buf <= word_next;
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench: 8N1 instance and even-parity instance, fast baud (16 clk per bit).
module tb_uart_rx_word;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int BT       = 16;
  localparam int TO_BITS  = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx0 = 1'b1;
  logic        rx1 = 1'b1;
  logic        ready0 = 1'b1;
  logic        ready1 = 1'b1;
  logic [15:0] data0, data1;
  logic        valid0, valid1;
  logic        fe_p0, pe_p0, to_p0, ov_p0;
  logic        fe_p1, pe_p1, to_p1, ov_p1;

  int n_cmp = 0;
  int n_fail = 0;

  int vc0 = 0, fe0 = 0, pe0 = 0, to0 = 0, ov0 = 0;
  int vc1 = 0, fe1 = 0, pe1 = 0, to1 = 0, ov1 = 0;
  logic [15:0] last0 = '0;
  logic [15:0] last1 = '0;

  always #5 clk = ~clk;

  uart_rx_word #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
    .BYTES_PER_WORD(2), .TIMEOUT_BITS(TO_BITS)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .i_rx(rx0), .i_ready(ready0),
    .o_data(data0), .o_valid(valid0), .o_frame_err(fe_p0),
    .o_parity_err(pe_p0), .o_timeout(to_p0), .o_overrun(ov_p0)
  );

  uart_rx_word #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
    .BYTES_PER_WORD(2), .TIMEOUT_BITS(TO_BITS)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .i_rx(rx1), .i_ready(ready1),
    .o_data(data1), .o_valid(valid1), .o_frame_err(fe_p1),
    .o_parity_err(pe_p1), .o_timeout(to_p1), .o_overrun(ov_p1)
  );

  // Event counters sampled on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (valid0) begin vc0 = vc0 + 1; last0 = data0; end
    if (fe_p0) fe0 = fe0 + 1;
    if (pe_p0) pe0 = pe0 + 1;
    if (to_p0) to0 = to0 + 1;
    if (ov_p0) ov0 = ov0 + 1;
    if (valid1) begin vc1 = vc1 + 1; last1 = data1; end
    if (fe_p1) fe1 = fe1 + 1;
    if (pe_p1) pe1 = pe1 + 1;
    if (to_p1) to1 = to1 + 1;
    if (ov_p1) ov1 = ov1 + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit which, input logic v);
    if (which) rx1 = v; else rx0 = v;
    repeat (BT) @(negedge clk);
  endtask

  task automatic send_byte(input bit which, input logic [7:0] b, input bit par_en,
                           input bit par, input bit stop);
    drive(which, 1'b0);
    for (int i = 0; i < 8; i++) drive(which, b[i]);
    if (par_en) drive(which, par);
    drive(which, stop);
    if (which) rx1 = 1'b1; else rx0 = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(4);
    n_cmp++;
    if ({data0, valid0, fe_p0, pe_p0, to_p0, ov_p0} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_dut0: got data=%h valid=%b flags=%b%b%b%b want all 0",
               data0, valid0, fe_p0, pe_p0, to_p0, ov_p0);
    end
    n_cmp++;
    if ({data1, valid1} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_dut1: got data=%h valid=%b want 0", data1, valid1);
    end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    int b_vc, b_err;
    b_vc  = vc0;
    b_err = fe0 + pe0 + to0 + ov0;
    send_byte(0, 8'h34, 0, 0, 1);
    send_byte(0, 8'h12, 0, 0, 1);
    idle(8);
    n_cmp++;
    if (last0 !== 16'h1234) begin
      n_fail++; $display("FAIL basic_data: got %h want 1234", last0);
    end
    n_cmp++;
    if (vc0 - b_vc !== 1) begin
      n_fail++; $display("FAIL basic_valid_cycles: got %0d want 1", vc0 - b_vc);
    end
    n_cmp++;
    if (fe0 + pe0 + to0 + ov0 - b_err !== 0) begin
      n_fail++; $display("FAIL basic_flags: got %0d pulses want 0", fe0 + pe0 + to0 + ov0 - b_err);
    end
  endtask

  task automatic test_glitch();
    int b_vc, b_err;
    b_vc  = vc0;
    b_err = fe0 + pe0 + to0 + ov0;
    rx0 = 1'b0;
    idle(3);
    rx0 = 1'b1;
    idle(40);
    n_cmp++;
    if (vc0 - b_vc !== 0 || fe0 + pe0 + to0 + ov0 - b_err !== 0) begin
      n_fail++; $display("FAIL glitch_quiet: got valid=%0d flags=%0d want 0/0",
                         vc0 - b_vc, fe0 + pe0 + to0 + ov0 - b_err);
    end
    send_byte(0, 8'h34, 0, 0, 1);
    send_byte(0, 8'h12, 0, 0, 1);
    idle(8);
    n_cmp++;
    if (last0 !== 16'h1234 || vc0 - b_vc !== 1) begin
      n_fail++; $display("FAIL glitch_after: got %h (%0d words) want 1234 (1)", last0, vc0 - b_vc);
    end
  endtask

  task automatic test_frame_err();
    int b_vc, b_fe;
    b_vc = vc0;
    b_fe = fe0;
    send_byte(0, 8'h99, 0, 0, 1);
    send_byte(0, 8'h55, 0, 0, 0);
    idle(20);
    n_cmp++;
    if (fe0 - b_fe !== 1) begin
      n_fail++; $display("FAIL frame_err_pulse: got %0d want 1", fe0 - b_fe);
    end
    send_byte(0, 8'hCD, 0, 0, 1);
    send_byte(0, 8'hAB, 0, 0, 1);
    idle(8);
    n_cmp++;
    if (last0 !== 16'hABCD || vc0 - b_vc !== 1) begin
      n_fail++; $display("FAIL frame_err_flush: got %h (%0d words) want abcd (1)", last0, vc0 - b_vc);
    end
  endtask

  task automatic test_parity();
    int b_vc, b_pe, b_oth;
    b_vc  = vc1;
    b_pe  = pe1;
    b_oth = fe1 + to1 + ov1;
    send_byte(1, 8'h07, 1, 0, 1);
    idle(8);
    n_cmp++;
    if (pe1 - b_pe !== 1) begin
      n_fail++; $display("FAIL parity_err_pulse: got %0d want 1", pe1 - b_pe);
    end
    send_byte(1, 8'h07, 1, 1, 1);
    send_byte(1, 8'h00, 1, 0, 1);
    idle(8);
    n_cmp++;
    if (last1 !== 16'h0007 || vc1 - b_vc !== 1) begin
      n_fail++; $display("FAIL parity_word: got %h (%0d words) want 0007 (1)", last1, vc1 - b_vc);
    end
    n_cmp++;
    if (pe1 - b_pe !== 1 || fe1 + to1 + ov1 - b_oth !== 0) begin
      n_fail++; $display("FAIL parity_other_flags: got pe=%0d other=%0d want 1/0",
                         pe1 - b_pe, fe1 + to1 + ov1 - b_oth);
    end
  endtask

  task automatic test_timeout();
    int b_vc, b_to;
    b_vc = vc0;
    b_to = to0;
    // Gap just under the limit keeps the partial byte.
    send_byte(0, 8'h11, 0, 0, 1);
    idle(BT * TO_BITS - 20);
    send_byte(0, 8'h22, 0, 0, 1);
    idle(8);
    n_cmp++;
    if (last0 !== 16'h2211 || to0 - b_to !== 0) begin
      n_fail++; $display("FAIL timeout_below: got %h to=%0d want 2211 to=0", last0, to0 - b_to);
    end
    send_byte(0, 8'h11, 0, 0, 1);
    idle(BT * TO_BITS + 10);
    n_cmp++;
    if (to0 - b_to !== 1) begin
      n_fail++; $display("FAIL timeout_pulse: got %0d want 1", to0 - b_to);
    end
    send_byte(0, 8'h22, 0, 0, 1);
    send_byte(0, 8'h33, 0, 0, 1);
    idle(8);
    n_cmp++;
    if (last0 !== 16'h3322 || vc0 - b_vc !== 2) begin
      n_fail++; $display("FAIL timeout_after: got %h (%0d words) want 3322 (2)", last0, vc0 - b_vc);
    end
  endtask

  task automatic test_overrun();
    int b_ov;
    b_ov = ov0;
    ready0 = 1'b0;
    send_byte(0, 8'h01, 0, 0, 1);
    send_byte(0, 8'h02, 0, 0, 1);
    idle(8);
    n_cmp++;
    if (data0 !== 16'h0201 || valid0 !== 1'b1) begin
      n_fail++; $display("FAIL overrun_first: got %h v=%b want 0201 v=1", data0, valid0);
    end
    send_byte(0, 8'h03, 0, 0, 1);
    send_byte(0, 8'h04, 0, 0, 1);
    idle(8);
    n_cmp++;
    if (ov0 - b_ov !== 1) begin
      n_fail++; $display("FAIL overrun_pulse: got %0d want 1", ov0 - b_ov);
    end
    n_cmp++;
    if (data0 !== 16'h0201 || valid0 !== 1'b1) begin
      n_fail++; $display("FAIL overrun_hold: got %h v=%b want 0201 v=1", data0, valid0);
    end
    ready0 = 1'b1;
    idle(2);
    n_cmp++;
    if (valid0 !== 1'b0) begin
      n_fail++; $display("FAIL overrun_accept: got v=%b want 0", valid0);
    end
  endtask

  task automatic test_reset_mid();
    int b_vc;
    send_byte(0, 8'h77, 0, 0, 1);
    drive(0, 1'b0);
    drive(0, 1'b1);
    drive(0, 1'b0);
    idle(5);
    rst_n = 1'b0;
    idle(2);
    rx0 = 1'b1;
    idle(2);
    n_cmp++;
    if ({data0, valid0, fe_p0, pe_p0, to_p0, ov_p0} !== 21'd0) begin
      n_fail++; $display("FAIL midreset_dut0: got data=%h valid=%b want 0", data0, valid0);
    end
    n_cmp++;
    if ({data1, valid1} !== 17'd0) begin
      n_fail++; $display("FAIL midreset_dut1: got data=%h valid=%b want 0", data1, valid1);
    end
    rst_n = 1'b1;
    idle(40);
    b_vc = vc0;
    send_byte(0, 8'h0A, 0, 0, 1);
    send_byte(0, 8'h0B, 0, 0, 1);
    idle(8);
    n_cmp++;
    if (last0 !== 16'h0B0A || vc0 - b_vc !== 1) begin
      n_fail++; $display("FAIL midreset_after: got %h (%0d words) want 0b0a (1)", last0, vc0 - b_vc);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_parity();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
